// File: rtl/mem_bus_sequencer_pkg.sv
// Shared definitions for the memory bus sequencer: FSM state encoding,
// requester port indices and the width of the WAIT-phase cycle counter.
package mem_bus_sequencer_pkg;

  // Sequencer FSM states. The encoding is fixed so that a checker or a
  // waveform reader can decode the debug state output directly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Requester port indices: port 0 is instruction fetch, port 1 is data.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // The WAIT counter must hold any legal timeout value (2..255).
  localparam int WaitCntWidth = 8;

endpackage : mem_bus_sequencer_pkg

// File: rtl/mem_bus_sequencer_rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational: the caller owns the
// last_grant register and decides when a grant is actually taken.
module mem_bus_sequencer_rr_arbiter2
  import mem_bus_sequencer_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_idx,
  output logic grant_valid
);

  // A lone requester always wins; on contention the port that was not
  // granted last time wins, so continuous requesters alternate.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = PORT1;
    end
  end

endmodule : mem_bus_sequencer_rr_arbiter2

// File: rtl/mem_bus_sequencer.sv
// Memory bus sequencer: arbitrates between an instruction-fetch port and a
// data port, time-multiplexes each transfer onto the shared address/data
// mux (address phase, then a data phase for writes), waits for the memory
// acknowledge with a timeout and returns read data or an error.
//
// Handshakes:
//   req/done   - a requester raises req and holds it (with we/addr/wdata
//                stable) until it sees its one-cycle done pulse; it must drop
//                req in that same cycle. err and rdata are valid only while
//                done is high. Requests seen outside IDLE simply stay pending.
//   bus_valid  - marks the ADDR and WDATA phases; mux_a/mux_b/mux_sel/bus_we
//                are meaningful only while it is high. The memory answers
//                with bus_ack (and bus_rdata for reads), which is looked at
//                only in WAIT; an ack at any other time is ignored.
module mem_bus_sequencer
  import mem_bus_sequencer_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 24,
  parameter int TimeoutCycles = 16   // legal range 2..255
) (
  input  logic                 clock,
  input  logic                 reset,      // asynchronous, active low
  input  logic                 req0,
  input  logic                 we0,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [DataWidth-1:0] wdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] wdata1,
  output logic                 done0,
  output logic                 done1,
  output logic                 err,
  output logic [DataWidth-1:0] rdata,
  output logic [AddrWidth-1:0] mux_a,
  output logic [DataWidth-1:0] mux_b,
  output logic                 mux_sel,
  output logic                 bus_valid,
  output logic                 bus_we,
  input  logic                 bus_ack,
  input  logic [DataWidth-1:0] bus_rdata,
  output state_t               state_dbg
);

  // Last WAIT counter value before the timeout fires: WAIT cycle n sees the
  // counter at n-1, so the error completion happens on cycle TimeoutCycles.
  localparam logic [WaitCntWidth-1:0] WaitLast =
    WaitCntWidth'(TimeoutCycles - 1);

  state_t                  state_q;
  logic                    last_grant_q;
  logic                    grant_q;
  logic                    we_q;
  logic [WaitCntWidth-1:0] wait_cnt_q;

  logic                    grant_idx;
  logic                    grant_valid;

  mem_bus_sequencer_rr_arbiter2 u_rr_arbiter2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign state_dbg = state_q;

  // Sequencer FSM: every bus-facing and requester-facing output is a
  // register updated on the transition into the state that owns it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT1;     // port 0 wins the first contention
      grant_q      <= PORT0;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      mux_a        <= '0;
      mux_b        <= '0;
      mux_sel      <= 1'b0;
      bus_valid    <= 1'b0;
      bus_we       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            grant_q      <= grant_idx;
            last_grant_q <= grant_idx;
            if (grant_idx == PORT1) begin
              mux_a  <= addr1;
              mux_b  <= wdata1;
              we_q   <= we1;
              bus_we <= we1;
            end else begin
              mux_a  <= addr0;
              mux_b  <= wdata0;
              we_q   <= we0;
              bus_we <= we0;
            end
            bus_valid <= 1'b1;
            mux_sel   <= 1'b0;
            state_q   <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (we_q) begin
            // Stay on the bus for the data phase; bus_we remains high.
            mux_sel <= 1'b1;
            state_q <= ST_WDATA;
          end else begin
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT;
          end
        end

        ST_WDATA: begin
          bus_valid  <= 1'b0;
          bus_we     <= 1'b0;
          mux_sel    <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          // An ack on the final allowed cycle still counts as a success.
          if (bus_ack) begin
            rdata   <= we_q ? '0 : bus_rdata;
            err     <= 1'b0;
            done0   <= (grant_q == PORT0);
            done1   <= (grant_q == PORT1);
            state_q <= ST_DONE;
          end else if (wait_cnt_q == WaitLast) begin
            rdata   <= '0;
            err     <= 1'b1;
            done0   <= (grant_q == PORT0);
            done1   <= (grant_q == PORT1);
            state_q <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          // err and rdata keep their value; only the done pulse ends here.
          done0      <= 1'b0;
          done1      <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mem_bus_sequencer

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer: reset values, round-robin
// contention, a table of single transfers (reads, writes, timeouts, ack on
// the last allowed cycle, stray and late acks) and a reset mid-transfer.
// Cycle numbering inside a transfer: cycle 1 is the cycle req is first
// driven (the FSM is in IDLE), so a read completes in cycle 4 and a write
// in cycle 5 when the ack arrives on the first WAIT cycle.
module tb_mem_bus_sequencer;
  import mem_bus_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        done0, done1, err, mux_sel, bus_valid, bus_we;
  logic [31:0] rdata, mux_b;
  logic [23:0] mux_a;
  state_t      state_dbg;

  mem_bus_sequencer #(
    .DataWidth(32), .AddrWidth(24), .TimeoutCycles(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err(err), .rdata(rdata),
    .mux_a(mux_a), .mux_b(mux_b), .mux_sel(mux_sel),
    .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [0:0]  exp_q[$];   // expected grant order under contention

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        port;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          ack_at;     // WAIT cycle carrying the ack, 0 = never
    logic [31:0] rd;         // bus_rdata driven with the ack
    logic        stray;      // drive an ack during the ADDR cycle
    logic        late;       // drive acks for 3 cycles after completion
    int          exp_lat;    // cycle in which done is expected
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic port, logic we, logic [23:0] addr,
                              logic [31:0] wdata, int ack_at,
                              logic [31:0] rd, logic stray, logic late,
                              int exp_lat, logic exp_err,
                              logic [31:0] exp_rdata);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata;
    v.ack_at = ack_at; v.rd = rd; v.stray = stray; v.late = late;
    v.exp_lat = exp_lat; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic port, input logic on, input vec_t v);
    if (port == PORT0) begin
      req0 = on; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req1 = on; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end
  endtask

  // One complete transfer. Inputs are driven and outputs sampled on the
  // falling edge, half a cycle away from the active edge.
  task automatic run_txn(input vec_t v, input string tag);
    int   cyc;
    int   base;
    bit   seen;
    logic my_done, other_done;
    base = v.we ? 3 : 2;     // WAIT cycle k falls in transfer cycle base+k
    @(negedge clock);
    drive_req(v.port, 1'b1, v);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      my_done    = (v.port == PORT0) ? done0 : done1;
      other_done = (v.port == PORT0) ? done1 : done0;
      check($sformatf("%s wrong_port_done c%0d", tag, cyc), other_done, 0);
      if (cyc == 2) begin
        check({tag, " addr_valid"}, bus_valid, 1);
        check({tag, " addr_sel"},   mux_sel, 0);
        check({tag, " addr_mux_a"}, mux_a, v.addr);
        check({tag, " addr_we"},    bus_we, v.we);
      end
      if (cyc == 3 && v.we) begin
        check({tag, " data_valid"}, bus_valid, 1);
        check({tag, " data_sel"},   mux_sel, 1);
        check({tag, " data_mux_b"}, mux_b, v.wdata);
        check({tag, " data_we"},    bus_we, 1);
      end
      if (cyc == base + 1) begin
        check({tag, " wait_valid"}, bus_valid, 0);
      end
      bus_ack   = 1'b0;
      bus_rdata = '0;
      if (my_done) begin
        seen = 1'b1;
        check({tag, " latency"}, cyc, v.exp_lat);
        check({tag, " err"},     err, v.exp_err);
        check({tag, " rdata"},   rdata, v.exp_rdata);
        drive_req(v.port, 1'b0, v);
      end else begin
        if (v.stray && cyc == 2) begin
          bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        end
        if (v.ack_at != 0 && cyc == base + v.ack_at) begin
          bus_ack = 1'b1; bus_rdata = v.rd;
        end
      end
    end
    if (!seen) begin
      check({tag, " done_seen"}, 0, 1);
      drive_req(v.port, 1'b0, v);
    end
    @(negedge clock);
    check({tag, " done_pulse_1cyc"}, {30'd0, done0, done1}, 0);
    check({tag, " back_to_idle"}, state_dbg, ST_IDLE);
    if (v.late) begin
      for (int i = 0; i < 3; i++) begin
        bus_ack = 1'b1; bus_rdata = 32'h0F0F0F0F;
        @(negedge clock);
        check($sformatf("%s late_ack_no_done %0d", tag, i),
              {30'd0, done0, done1}, 0);
        check($sformatf("%s late_ack_idle %0d", tag, i), state_dbg, ST_IDLE);
      end
      bus_ack = 1'b0; bus_rdata = '0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    int   cyc;
    int   grants;

    //           port   we    addr        wdata         ack rd            stray late lat err rdata
    vecs[0] = mk(PORT0, 1'b0, 24'h001234, 32'h00000000, 1,  32'hDEADBEEF, 1'b0, 1'b0, 4,  1'b0, 32'hDEADBEEF);
    vecs[1] = mk(PORT1, 1'b1, 24'hABCDEF, 32'h0BADF00D, 1,  32'h55555555, 1'b0, 1'b0, 5,  1'b0, 32'h00000000);
    vecs[2] = mk(PORT0, 1'b0, 24'h00BEEF, 32'h00000000, 0,  32'h00000000, 1'b0, 1'b1, 19, 1'b1, 32'h00000000);
    vecs[3] = mk(PORT1, 1'b0, 24'h123456, 32'h00000000, 16, 32'h12345678, 1'b1, 1'b0, 19, 1'b0, 32'h12345678);
    vecs[4] = mk(PORT0, 1'b1, 24'hFFFFFF, 32'hCAFEF00D, 3,  32'hFFFFFFFF, 1'b1, 1'b0, 7,  1'b0, 32'h00000000);
    vecs[5] = mk(PORT1, 1'b0, 24'h000001, 32'h00000000, 2,  32'hA5A5A5A5, 1'b0, 1'b0, 5,  1'b0, 32'hA5A5A5A5);
    vecs[6] = mk(PORT1, 1'b1, 24'h800000, 32'h13579BDF, 0,  32'h00000000, 1'b0, 1'b1, 20, 1'b1, 32'h00000000);
    vecs[7] = mk(PORT0, 1'b0, 24'h0000F0, 32'h00000000, 15, 32'h87654321, 1'b0, 1'b0, 18, 1'b0, 32'h87654321);

    // Reset with both requests already asserted.
    reset = 1'b0;
    req0 = 1'b1; addr0 = 24'h000AAA; we0 = 1'b0;
    req1 = 1'b1; addr1 = 24'h000BBB; we1 = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_state",     state_dbg, ST_IDLE);
    check("reset_ctrl_outs", {26'd0, done0, done1, err, mux_sel, bus_valid, bus_we}, 0);
    check("reset_rdata",     rdata, 0);
    check("reset_mux_a",     mux_a, 0);
    check("reset_mux_b",     mux_b, 0);

    // Contention: both ports keep requesting; grants must alternate from 0.
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    bus_ack   = 1'b1;
    bus_rdata = 32'hC0DE0000;
    reset     = 1'b1;
    grants    = 0;
    cyc       = 0;
    while (grants < 4 && cyc < 80) begin
      @(negedge clock);
      cyc++;
      check($sformatf("contend_single_done c%0d", cyc), {31'd0, done0 & done1}, 0);
      if (done0 || done1) begin
        check($sformatf("contend_grant_%0d", grants), {31'd0, done1},
              {31'd0, exp_q.pop_front()});
        check($sformatf("contend_err_%0d", grants), err, 0);
        check($sformatf("contend_rdata_%0d", grants), rdata, 32'hC0DE0000);
        grants++;
      end
    end
    check("contend_grant_count", grants, 4);
    req0 = 1'b0; req1 = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    exp_q.delete();

    // Table of single transfers.
    foreach (vecs[i]) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a WAIT phase.
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000F0F; wdata0 = '0;
    repeat (3) @(negedge clock);   // now in transfer cycle 4 = WAIT cycle 2
    check("midrst_in_wait", state_dbg, ST_WAIT);
    #1 reset = 1'b0;
    #1;
    check("midrst_state",     state_dbg, ST_IDLE);
    check("midrst_ctrl_outs", {26'd0, done0, done1, err, mux_sel, bus_valid, bus_we}, 0);
    check("midrst_rdata",     rdata, 0);
    check("midrst_mux_a",     mux_a, 0);
    check("midrst_mux_b",     mux_b, 0);
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("midrst_no_done %0d", i), {30'd0, done0, done1}, 0);
    end
    reset = 1'b1;
    v = mk(PORT0, 1'b0, 24'h000321, 32'h0, 1, 32'h600DCAFE, 1'b0, 1'b0, 4, 1'b0, 32'h600DCAFE);
    run_txn(v, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_bus_sequencer
